vc_buffer_bank: RTL

- Parametrised multi-channel successor to the single-VC buffer wrapper.
- Holds NUM_VC independent virtual-channel FIFOs behind a shared write port, steered by a VC index.
- Each VC has its own read strobe, data output, status flags and sticky error.
- Sits between the TC-to-VC mapper and the VC arbiter in the interconnect.

---
 rtl/vc_buf_pkg.sv | 31 +++
 rtl/vc_fifo_slice.sv | 98 +++++++++
 rtl/vc_buffer_bank.sv | 102 ++++++++++
 3 files changed

// File: rtl/vc_buf_pkg.sv
// -----------------------------------------------------------------------------
// vc_buf_pkg
// Shared definitions for the virtual-channel buffer bank:
//   - clog2 helper used for pointer, count and VC-index widths
//   - default data width, depth and channel count
//   - bit positions of the per-slice status flag vector
// No ports (package).
// -----------------------------------------------------------------------------
package vc_buf_pkg;

   localparam int BW_DEF     = 6;
   localparam int DEPTH_DEF  = 16;
   localparam int NUM_VC_DEF = 2;

   // Bit positions inside the flag vector each slice reports to the top
   localparam int FULL      = 0;
   localparam int EMPTY     = 1;
   localparam int AF        = 2;
   localparam int AE        = 3;
   localparam int ERR       = 4;
   localparam int NUM_FLAGS = 5;

   // Ceiling log2; clog2(1) = 0
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/vc_fifo_slice.sv
// -----------------------------------------------------------------------------
// vc_fifo_slice
// Storage, pointers, occupancy count, status flags and sticky error for one
// virtual channel.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   wr_en, data_in    write request (already steered to this VC)
//   rd_en             pop request
//   data_out          registered read data, holds when no pop
//   flags             {ERR, AE, AF, EMPTY, FULL} at vc_buf_pkg positions
//   count             registered occupancy
//   peak              high-water mark (only with VC_BUF_OCC_EN defined)
// -----------------------------------------------------------------------------
module vc_fifo_slice
   import vc_buf_pkg::*;
#(
   parameter int  BW     = BW_DEF,
   parameter int  DEPTH  = DEPTH_DEF,
   parameter int  AF_TOL = 1,
   parameter int  AE_TOL = 1,
   localparam int AW     = clog2(DEPTH),
   localparam int CW     = clog2(DEPTH + 1)
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [BW-1:0]        data_in,
   input  logic                 rd_en,
   output logic [BW-1:0]        data_out,
   output logic [NUM_FLAGS-1:0] flags,
   output logic [CW-1:0]        count
`ifdef VC_BUF_OCC_EN
   ,
   output logic [CW-1:0]        peak
`endif
);

   logic [BW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_nxt;
   logic          do_wr;
   logic          do_rd;
   logic          ovf;
   logic          udf;

   // A pop frees a slot in the same cycle, so a full slice still accepts a
   // write that arrives together with a pop. A pop on an empty slice is never
   // serviced, even if a write lands in the same cycle.
   always_comb begin
      do_wr     = wr_en && (!flags[FULL] || rd_en);
      do_rd     = rd_en && !flags[EMPTY];
      ovf       = wr_en && flags[FULL] && !rd_en;
      udf       = rd_en && flags[EMPTY];
      count_nxt = count + CW'(do_wr) - CW'(do_rd);
   end

   // Storage is never cleared; reset only rewinds pointers so stale entries
   // cannot be reached.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= data_in;
   end

   // When full with write+pop, wr_ptr == rd_ptr: the read below samples the
   // old entry because the write above is non-blocking.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         data_out    <= '0;
         flags       <= '0;
         flags[EMPTY] <= 1'b1;
         flags[AE]    <= 1'b1;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) begin
            rd_ptr   <= rd_ptr + AW'(1);
            data_out <= mem[rd_ptr];
         end
         count      <= count_nxt;
         // Flags come from the next count so they line up with count
         flags[FULL]  <= (count_nxt == CW'(DEPTH));
         flags[EMPTY] <= (count_nxt == '0);
         flags[AF]    <= (count_nxt >= CW'(DEPTH - AF_TOL));
         flags[AE]    <= (count_nxt <= CW'(AE_TOL));
         flags[ERR]   <= flags[ERR] | ovf | udf;
      end
   end

`ifdef VC_BUF_OCC_EN
   always_ff @(posedge clk) begin
      if (reset)                 peak <= '0;
      else if (count_nxt > peak) peak <= count_nxt;
   end
`endif

endmodule

// File: rtl/vc_buffer_bank.sv
// -----------------------------------------------------------------------------
// vc_buffer_bank
// NUM_VC independent virtual-channel FIFOs behind one shared write port,
// steered by wr_vc. Each VC has its own pop strobe, data output, flags and
// sticky error. Optional occupancy outputs are enabled with VC_BUF_OCC_EN.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   valid_in          write strobe
//   wr_vc             target VC of the write
//   data_in           write data
//   vc_rd             per-VC pop strobes
//   vc_data_out       per-VC read data, VC i at [i*BW +: BW]
//   vc_full/vc_empty/vc_almost_full/vc_almost_empty/vc_error  per-VC status
//   wr_vc_invalid     one-cycle registered pulse for a write to wr_vc >= NUM_VC
//   vc_count, vc_peak per-VC count and high-water mark (VC_BUF_OCC_EN only)
// -----------------------------------------------------------------------------
module vc_buffer_bank
   import vc_buf_pkg::*;
#(
   parameter int  BW     = BW_DEF,
   parameter int  DEPTH  = DEPTH_DEF,
   parameter int  NUM_VC = NUM_VC_DEF,
   parameter int  AF_TOL = 1,
   parameter int  AE_TOL = 1,
   localparam int VC_W   = (NUM_VC > 1) ? clog2(NUM_VC) : 1,
   localparam int CW     = clog2(DEPTH + 1)
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_in,
   input  logic [VC_W-1:0]      wr_vc,
   input  logic [BW-1:0]        data_in,
   input  logic [NUM_VC-1:0]    vc_rd,
   output logic [NUM_VC*BW-1:0] vc_data_out,
   output logic [NUM_VC-1:0]    vc_full,
   output logic [NUM_VC-1:0]    vc_empty,
   output logic [NUM_VC-1:0]    vc_almost_full,
   output logic [NUM_VC-1:0]    vc_almost_empty,
   output logic [NUM_VC-1:0]    vc_error,
   output logic                 wr_vc_invalid
`ifdef VC_BUF_OCC_EN
   ,
   output logic [NUM_VC*CW-1:0] vc_count,
   output logic [NUM_VC*CW-1:0] vc_peak
`endif
);

   logic [NUM_VC-1:0]    wr_sel;
   logic [NUM_VC*CW-1:0] cnt_all;

   // Out-of-range indices match no slice, so such writes fall away here
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         wr_sel[i] = valid_in && (wr_vc == VC_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) wr_vc_invalid <= 1'b0;
      else       wr_vc_invalid <= valid_in && (int'(wr_vc) >= NUM_VC);
   end

   for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
      logic [NUM_FLAGS-1:0] flags;

      vc_fifo_slice #(
         .BW     (BW),
         .DEPTH  (DEPTH),
         .AF_TOL (AF_TOL),
         .AE_TOL (AE_TOL)
      ) u_slice (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (wr_sel[i]),
         .data_in  (data_in),
         .rd_en    (vc_rd[i]),
         .data_out (vc_data_out[i*BW +: BW]),
         .flags    (flags),
         .count    (cnt_all[i*CW +: CW])
`ifdef VC_BUF_OCC_EN
         ,
         .peak     (vc_peak[i*CW +: CW])
`endif
      );

      assign vc_full[i]         = flags[FULL];
      assign vc_empty[i]        = flags[EMPTY];
      assign vc_almost_full[i]  = flags[AF];
      assign vc_almost_empty[i] = flags[AE];
      assign vc_error[i]        = flags[ERR];
   end

`ifdef VC_BUF_OCC_EN
   assign vc_count = cnt_all;
`else
   // Counts are internal only in this build
   logic unused_cnt;
   assign unused_cnt = ^cnt_all;
`endif

endmodule
